// File: rtl/sand_pkg.sv
// Shared definitions for the sand grid: cell encodings, word packing and
// the sweep sequencer's state encoding.
package sand_pkg;

  typedef enum logic [1:0] {
    AIR     = 2'd0,
    SAND    = 2'd1,
    SAND_AM = 2'd2,
    WALL    = 2'd3
  } cell_t;

  localparam int unsigned CELLS_PER_WORD = 16;
  localparam int unsigned CELL_W         = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_R,
    S_CAP_R,
    S_CAP_F,
    S_WR_R,
    S_WR_F,
    S_ADV
  } sweep_state_t;

endpackage

// File: rtl/sand_sweep_ctrl.sv
// Frame sequencer: walks region/floor word pairs bottom-up through the shared
// grid RAM, feeds them to sand_update and writes the results back.
module sand_sweep_ctrl
  import sand_pkg::*;
#(
  parameter int unsigned ROW_WORDS  = 40,
  parameter int unsigned ROWS       = 480,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned SPOUT_WORD = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       upd_region,
  output logic [31:0]       upd_floor,
  output logic              upd_screenbegin,
  output logic              upd_screenend,
  output logic              upd_screenbottom,
  output logic              upd_spout,
  input  logic [31:0]       upd_new_region,
  input  logic [31:0]       upd_new_floor
);

  localparam int unsigned ROW_W  = (ROWS > 2)      ? $clog2(ROWS)      : 1;
  localparam int unsigned WORD_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

  localparam logic [ROW_W-1:0]  FIRST_ROW = ROW_W'(ROWS - 2);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(ROW_WORDS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_WORDS);

  if (ROW_WORDS * ROWS > (2 ** ADDR_W)) begin : g_bad_addr_w
    $error("sand_sweep_ctrl: ADDR_W too small for ROW_WORDS*ROWS");
  end

  sweep_state_t      state;
  logic [ROW_W-1:0]  row;
  logic [WORD_W-1:0] word;
  logic              rd_cap;

  logic              last_word;
  logic              sweep_end;
  logic [ROW_W-1:0]  next_row;
  logic [WORD_W-1:0] next_word;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0]  r,
                                                input logic [WORD_W-1:0] w);
    return ADDR_W'(r) * ROW_STEP + ADDR_W'(w);
  endfunction

  // {screenbegin, screenend, screenbottom, spout} for region row r, word w
  function automatic logic [3:0] flags_of(input logic [ROW_W-1:0]  r,
                                          input logic [WORD_W-1:0] w);
    return {w == '0,
            w == LAST_WORD,
            r == FIRST_ROW,
            (r == '0) && (w == WORD_W'(SPOUT_WORD))};
  endfunction

  always_comb begin
    last_word = (word == LAST_WORD);
    sweep_end = last_word && (row == '0);
    next_word = last_word ? '0 : word + 1'b1;
    next_row  = last_word ? row - 1'b1 : row;
  end

  // Write data follows the updater combinationally; upd_* are frozen during
  // both write states, so it stays stable across a stalled write.
  always_comb begin
    mem_wdata = '0;
    if (mem_we) begin
      mem_wdata = (state == S_WR_F) ? upd_new_floor : upd_new_region;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      row              <= '0;
      word             <= '0;
      rd_cap           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      upd_region       <= '0;
      upd_floor        <= '0;
      upd_screenbegin  <= 1'b0;
      upd_screenend    <= 1'b0;
      upd_screenbottom <= 1'b0;
      upd_spout        <= 1'b0;
    end else begin
      rd_cap <= mem_req && mem_gnt && !mem_we;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !done) begin
            row      <= FIRST_ROW;
            word     <= '0;
            {upd_screenbegin, upd_screenend, upd_screenbottom, upd_spout}
                     <= flags_of(FIRST_ROW, '0);
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_of(FIRST_ROW, '0);
            state    <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (mem_gnt) begin
            mem_addr <= mem_addr + ROW_STEP;
            state    <= S_CAP_R;
          end
        end
        S_CAP_R: begin
          // Region data lands only in the first CAP_R cycle; later cycles
          // are floor-read stalls and must not overwrite it.
          if (rd_cap) begin
            upd_region <= mem_rdata;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_CAP_F;
          end
        end
        S_CAP_F: begin
          upd_floor <= mem_rdata;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= addr_of(row, word);
          state     <= S_WR_R;
        end
        S_WR_R: begin
          if (mem_gnt) begin
            mem_addr <= mem_addr + ROW_STEP;
            state    <= S_WR_F;
          end
        end
        S_WR_F: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_ADV;
          end
        end
        S_ADV: begin
          if (sweep_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            row      <= next_row;
            word     <= next_word;
            {upd_screenbegin, upd_screenend, upd_screenbottom, upd_spout}
                     <= flags_of(next_row, next_word);
            mem_req  <= 1'b1;
            mem_addr <= addr_of(next_row, next_word);
            state    <= S_RD_R;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// Directed bench for sand_sweep_ctrl on a 2-word x 3-row grid with a simple
// deterministic stand-in updater and a behavioural single-port RAM.
module tb_sand_sweep_ctrl;
  import sand_pkg::*;

  localparam int unsigned RW = 2;
  localparam int unsigned RS = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned SP = 1;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic [31:0]   mem_rdata;
  logic [31:0]   upd_region;
  logic [31:0]   upd_floor;
  logic          upd_screenbegin;
  logic          upd_screenend;
  logic          upd_screenbottom;
  logic          upd_spout;
  logic [31:0]   upd_new_region;
  logic [31:0]   upd_new_floor;

  sand_sweep_ctrl #(
    .ROW_WORDS (RW),
    .ROWS      (RS),
    .ADDR_W    (AW),
    .SPOUT_WORD(SP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_gnt         (mem_gnt),
    .mem_rdata       (mem_rdata),
    .upd_region      (upd_region),
    .upd_floor       (upd_floor),
    .upd_screenbegin (upd_screenbegin),
    .upd_screenend   (upd_screenend),
    .upd_screenbottom(upd_screenbottom),
    .upd_spout       (upd_spout),
    .upd_new_region  (upd_new_region),
    .upd_new_floor   (upd_new_floor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in updater: region' = region ^ floor, floor' = floor + 1
  assign upd_new_region = upd_region ^ upd_floor;
  assign upd_new_floor  = upd_floor + 32'd1;

  logic        stall;
  logic [1:0]  wait_cnt;
  logic        ram_init;
  logic [31:0] ram [0:7];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  flags;
  } vec_t;

  vec_t log_q[$];

  assign mem_gnt = stall ? (wait_cnt == 2'd3) : 1'b1;

  always @(posedge clk) begin
    wait_cnt <= (mem_req && !mem_gnt) ? wait_cnt + 2'd1 : 2'd0;
    if (ram_init) begin
      for (int i = 0; i < 8; i++) ram[i] <= 32'(i * 17);
    end else if (mem_req && mem_gnt) begin
      log_q.push_back('{mem_we, 4'(mem_addr), mem_wdata,
                        {upd_screenbegin, upd_screenend, upd_screenbottom, upd_spout}});
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic init_ram();
    @(negedge clk);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
    log_q.delete();
  endtask

  task automatic check_idle_zero(input string name);
    check(name, {busy, done, mem_req, mem_we, 4'(mem_addr), mem_wdata, upd_screenbegin,
                 upd_screenend, upd_screenbottom, upd_spout}, '0);
    check({name, "_upd"}, {upd_region, upd_floor}, '0);
  endtask

  // Pulses start and watches busy/done until the sweep ends (or abort_at).
  task automatic run_sweep(input bit chk_stab, input int abort_at, input bit extra_start,
                           output int busy_cyc, output int done_cyc, output int ndone);
    logic          prev_st;
    logic [AW-1:0] pa;
    logic          pw;
    logic [31:0]   pd;
    prev_st  = 1'b0;
    busy_cyc = 0;
    done_cyc = 0;
    ndone    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
        if (extra_start) start = 1'b1;
      end
      if (extra_start && c == 10) start = 1'b1;
      if (chk_stab && prev_st && mem_req) begin
        check("stall_addr", 64'(mem_addr), 64'(pa));
        check("stall_we", 64'(mem_we), 64'(pw));
        check("stall_wdata", 64'(mem_wdata), 64'(pd));
      end
      prev_st = mem_req && !mem_gnt;
      pa = mem_addr;
      pw = mem_we;
      pd = mem_wdata;
      if (abort_at == c) begin
        check("abort_at_wr_r", {mem_req, mem_we, 4'(mem_addr)}, {2'b11, 4'd3});
        reset_n = 1'b0;
        #1;
        check_idle_zero("async_reset_outputs");
        return;
      end
      if (done_cyc != 0 && c >= done_cyc + 4) begin
        check("busy_after_sweep", 64'(busy), 64'd0);
        return;
      end
    end
    check("sweep_timeout", 64'd1, 64'd0);
  endtask

  vec_t        tbl[16];
  logic [31:0] fin[6];

  function automatic vec_t mk(input logic we, input logic [3:0] a, input logic [31:0] d,
                              input logic [3:0] f);
    return '{we, a, d, f};
  endfunction

  task automatic check_sequence(input string tag);
    check({tag, "_count"}, 64'(log_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < log_q.size()) begin
        check($sformatf("%s_acc%0d", tag, i), {log_q[i].we, log_q[i].addr},
              {tbl[i].we, tbl[i].addr});
        check($sformatf("%s_flags%0d", tag, i), 64'(log_q[i].flags), 64'(tbl[i].flags));
        if (tbl[i].we) check($sformatf("%s_wdata%0d", tag, i), 64'(log_q[i].wdata),
                             64'(tbl[i].wdata));
      end
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 6; i++) check($sformatf("%s_ram%0d", tag, i), 64'(ram[i]), 64'(fin[i]));
  endtask

  initial begin
    int bc, dc, nd;
    bit saw3;
    // flags = {begin, end, bottom, spout}; RAM initialised to i*0x11
    tbl[0]  = mk(0, 2, 0, 4'b1010);  tbl[1]  = mk(0, 4, 0, 4'b1010);
    tbl[2]  = mk(1, 2, 32'h66, 4'b1010); tbl[3] = mk(1, 4, 32'h45, 4'b1010);
    tbl[4]  = mk(0, 3, 0, 4'b0110);  tbl[5]  = mk(0, 5, 0, 4'b0110);
    tbl[6]  = mk(1, 3, 32'h66, 4'b0110); tbl[7] = mk(1, 5, 32'h56, 4'b0110);
    tbl[8]  = mk(0, 0, 0, 4'b1000);  tbl[9]  = mk(0, 2, 0, 4'b1000);
    tbl[10] = mk(1, 0, 32'h66, 4'b1000); tbl[11] = mk(1, 2, 32'h67, 4'b1000);
    tbl[12] = mk(0, 1, 0, 4'b0101);  tbl[13] = mk(0, 3, 0, 4'b0101);
    tbl[14] = mk(1, 1, 32'h77, 4'b0101); tbl[15] = mk(1, 3, 32'h67, 4'b0101);
    fin = '{32'h66, 32'h77, 32'h67, 32'h67, 32'h45, 32'h56};

    reset_n  = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    ram_init = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    reset_n = 1'b1;

    // Grant tied high: sequence, timing, final contents
    init_ram();
    run_sweep(1'b0, 0, 1'b0, bc, dc, nd);
    check("busy_cycles", 64'(bc), 64'd24);
    check("done_cycle", 64'(dc), 64'd25);
    check("done_count", 64'(nd), 64'd1);
    check_sequence("nostall");
    check_ram("nostall");

    // Grant held off 3 cycles per request
    stall = 1'b1;
    init_ram();
    run_sweep(1'b1, 0, 1'b0, bc, dc, nd);
    check("stall_done_count", 64'(nd), 64'd1);
    check_sequence("stall");
    check_ram("stall");
    stall = 1'b0;

    // Reset during WR_R of the second word
    init_ram();
    run_sweep(1'b0, 10, 1'b0, bc, dc, nd);
    repeat (3) @(negedge clk);
    check_idle_zero("reset_held");
    saw3 = 1'b0;
    foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == 4'd3) saw3 = 1'b1;
    check("no_write_addr3", 64'(saw3), 64'd0);
    check("abort_ram3", 64'(ram[3]), 64'h33);
    check("abort_ram2", 64'(ram[2]), 64'h66);
    check("abort_ram4", 64'(ram[4]), 64'h45);
    reset_n = 1'b1;
    init_ram();
    run_sweep(1'b0, 0, 1'b0, bc, dc, nd);
    check("post_reset_done_count", 64'(nd), 64'd1);
    check_sequence("postreset");
    check_ram("postreset");

    // start while busy and coincident with done is ignored
    init_ram();
    run_sweep(1'b0, 0, 1'b1, bc, dc, nd);
    check("extra_start_done_cycle", 64'(dc), 64'd25);
    check("extra_start_done_count", 64'(nd), 64'd1);
    check("extra_start_busy_cycles", 64'(bc), 64'd24);
    check_ram("extra_start");
    repeat (10) @(negedge clk);
    check("idle_after_ignored_start", {busy, done, mem_req}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sand_sweep_ctrl.md
Name: sand_sweep_ctrl

Overview:
Frame-level sequencer that drives the combinational sand_update cell updater against the packed grid RAM. Once per frame it walks every region/floor word pair bottom-up and reads both words through an arbitrated single-port RAM interface. It presents them to the updater with the correct edge/spout flags and writes the updated words back. It sits between the grid RAM arbiter, which it shares with VGA scanout, and sand_update.

Parameters:
ROW_WORDS, 40, 32-bit words per grid row (16 cells of 2 bits each per word).
ROWS, 480, grid rows.
ADDR_W, 15, RAM word-address width; must satisfy ROW_WORDS*ROWS <= 2**ADDR_W.
SPOUT_WORD, 20, word index in row 0 that receives spout injection.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  frame tick (vsync-derived); one-cycle pulse begins a sweep
busy  out  1  high from sweep acceptance until done
done  out  1  one-cycle pulse after the final write of a sweep is granted
mem_req  out  1  RAM access request
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  word address = row*ROW_WORDS + word
mem_wdata  out  32  write data
mem_gnt  in  1  arbiter grant; the access completes in any cycle where mem_req && mem_gnt
mem_rdata  in  32  read data, valid the cycle after a granted read
upd_region  out  32  registered region word sent to sand_update
upd_floor  out  32  registered floor word sent to sand_update
upd_screenbegin  out  1  word index == 0
upd_screenend  out  1  word index == ROW_WORDS-1
upd_screenbottom  out  1  floor row == ROWS-1
upd_spout  out  1  region row == 0 and word == SPOUT_WORD
upd_new_region  in  32  updater result, combinational from upd_* outputs
upd_new_floor  in  32  updater result

Behaviour:
- Reset values: every output is 0, state is IDLE, row/word counters are 0. Reset is asynchronous and may assert mid-sweep. The controller then abandons the sweep with no further access. RAM may be left partially updated, and this is accepted.
- Sweep order: the region row runs from ROWS-2 down to 0, and the floor row is region row+1. Within a row, words run from 0 to ROW_WORDS-1. The bottom-up order means a grain moves at most one row per frame.
- FSM:
  - IDLE: when start, load row=ROWS-2, word=0, busy=1, go to RD_R. start is ignored in every other state.
  - RD_R: mem_req=1, mem_we=0, addr=region address; hold until granted, then go to CAP_R.
  - CAP_R: upd_region<=mem_rdata; issue the floor read (addr+ROW_WORDS) in the same cycle; hold until granted, then go to CAP_F.
  - CAP_F: upd_floor<=mem_rdata; go to WR_R.
  - WR_R: mem_we=1, wdata=upd_new_region, region address; hold until granted, then go to WR_F.
  - WR_F: mem_we=1, wdata=upd_new_floor, floor address; hold until granted, then go to ADV.
  - ADV: if word<ROW_WORDS-1, word++ and go to RD_R. Else if row>0, row-- with word=0 and go to RD_R. Else pulse done, drop busy, and go to IDLE.
- Read data is captured exactly one cycle after the grant cycle, even if that cycle also carries a new request.
- mem_addr, mem_we and mem_wdata stay stable while mem_req is high and ungranted. mem_req is low in IDLE, CAP_F and ADV.
- upd_* flags are registered from the counters and stay stable from RD_R through WR_F of each word.
- Latency with the grant tied high: 6 cycles per word. A full sweep is 6*ROW_WORDS*(ROWS-1) cycles plus 1 for IDLE exit. With defaults that is 114,961 cycles, well under one 50 MHz frame.
- Address arithmetic is ADDR_W-bit unsigned, and the row multiply is a constant multiply. No wrap-around occurs given the parameter constraint.
- A start arriving in the same cycle as done is ignored; the next sweep waits for the next tick.

Decomposition:
- Package sand_pkg holds:
  - cell codes AIR/SAND/SAND_AM/WALL;
  - CELLS_PER_WORD=16 and CELL_W=2;
  - the sweep state enum.
- No sub-module; sand_update is instantiated beside this block at the parent level.

Test Plan:
- ROW_WORDS=2, ROWS=3, grant tied high, start pulse -> access sequence at addresses 2R,4R,2W,4W,3R,5R,3W,5W,0R,2R,0W,2W,1R,3R,1W,3W; done pulse at cycle 25; busy high cycles 1-24.
- Same config, RAM word 0 = 0x40000000 (sand in cell 15) and word 2 = 0, real sand_update attached -> afterwards word 0 = 0 and word 2 = 0x80000000 (SAND_AM).
- Grant held low 3 cycles on every request -> addr/we/wdata unchanged while stalled; final RAM contents identical to the no-stall run.
- reset_n low during WR_R of the second word -> outputs 0 immediately; no write to address 3; the next start runs a full, correct sweep.
- start pulsed again while busy and coincident with done -> ignored; exactly one done per accepted start.
- Flag check with defaults: upd_spout high only at row 0/word 20; upd_screenbottom high only while row==478; begin/end high at words 0 and 39.
